// File: rtl/approx_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : approx_mul_pkg
// Description : Shared constants, parameter legality checks and the pair
//               sum/carry vector type for approx_mul_pipe.
// Revision    : 1.0
// ============================================================================
package approx_mul_pkg;

    localparam int C_MAX_WIDTH = 16;
    localparam int C_VEC_W     = C_MAX_WIDTH + 1;

    // One pair of partial-product rows spans WIDTH+1 relative columns;
    // sized for the widest legal operand, upper bits are zero.
    typedef struct packed {
        logic [C_VEC_W-1:0] t;
        logic [C_VEC_W-1:0] cy;
    } pair_tc_t;

    function automatic bit width_ok(input int w);
        return (w >= 4) && (w <= C_MAX_WIDTH) && ((w % 2) == 0);
    endfunction

    function automatic bit approx_cols_ok(input int w, input int ac);
        return (ac >= 0) && (ac <= 2 * w);
    endfunction

    function automatic int npair(input int w);
        return w / 2;
    endfunction

    function automatic int pw(input int w);
        return 2 * w;
    endfunction

    // Vector count after one level of 3:2 compression.
    function automatic int csa_next(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int csa_count_at(input int n, input int lvl);
        int m;
        m = n;
        for (int i = 0; i < lvl; i++) m = csa_next(m);
        return m;
    endfunction

    function automatic int csa_levels(input int n);
        int m;
        int l;
        m = n;
        l = 0;
        while (m > 2) begin
            m = csa_next(m);
            l++;
        end
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_ha_row.sv
`default_nettype none
// ============================================================================
// Module      : approx_ha_row
// Description : Combinational sum/carry vectors for one pair of partial-
//               product rows, with OR-compression in the low columns.
// Revision    : 1.0
// ============================================================================
module approx_ha_row
    import approx_mul_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PAIR_IDX    = 0,
    parameter int APPROX_COLS = 4
) (
    input  logic [1:0]       i_x_pair,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_exact,
    output pair_tc_t         o_tc
);

    logic [WIDTH:0] w_a;
    logic [WIDTH:0] w_b;
    logic [WIDTH:0] w_apx;
    logic [WIDTH:0] w_t;
    logic [WIDTH:0] w_cy;

    // Row 2k sits in relative columns 0..WIDTH-1, row 2k+1 one column higher.
    assign w_a = {1'b0, {WIDTH{i_x_pair[0]}} & i_y};
    assign w_b = {{WIDTH{i_x_pair[1]}} & i_y, 1'b0};

    for (genvar gc = 0; gc <= WIDTH; gc++) begin : g_col
        localparam bit C_APX_COL = (2 * PAIR_IDX + gc) < APPROX_COLS;
        assign w_apx[gc] = ~i_exact & C_APX_COL;
    end

    assign w_t  = (w_apx & (w_a | w_b)) | (~w_apx & (w_a ^ w_b));
    assign w_cy = ~w_apx & w_a & w_b;

    assign o_tc.t  = C_VEC_W'(w_t);
    assign o_tc.cy = C_VEC_W'(w_cy);

endmodule
`default_nettype wire

// File: rtl/approx_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : approx_mul_pipe
// Description : Three-stage valid/ready unsigned multiplier with per-
//               transaction exact or low-column approximate compression.
// Revision    : 1.0
// ============================================================================
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 exact,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 p_exact
);

    localparam int C_NPAIR = npair(WIDTH);
    localparam int C_PW    = pw(WIDTH);
    localparam int C_NVEC  = 2 * C_NPAIR;
    localparam int C_NLEV  = csa_levels(C_NVEC);

    if (!width_ok(WIDTH) || !approx_cols_ok(WIDTH, APPROX_COLS)) begin : g_param_check
        $error("approx_mul_pipe: illegal WIDTH or APPROX_COLS");
    end

    logic            w_stall;
    pair_tc_t        w_tc     [C_NPAIR];
    logic [C_PW-1:0] w_tree   [C_NLEV+1][C_NVEC];

    logic            r_s1_valid;
    logic            r_s1_exact;
    pair_tc_t        r_s1_tc  [C_NPAIR];
    logic            r_s2_valid;
    logic            r_s2_exact;
    logic [C_PW-1:0] r_s2_sum;
    logic [C_PW-1:0] r_s2_car;

    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    for (genvar gk = 0; gk < C_NPAIR; gk++) begin : g_pair
        approx_ha_row #(
            .WIDTH       (WIDTH),
            .PAIR_IDX    (gk),
            .APPROX_COLS (APPROX_COLS)
        ) u_row (
            .i_x_pair (x[2*gk+1:2*gk]),
            .i_y      (y),
            .i_exact  (exact),
            .o_tc     (w_tc[gk])
        );

        // Leaf vectors of the tree: pair sum and doubled carry at weight 2^2k.
        assign w_tree[0][2*gk]   = C_PW'(r_s1_tc[gk].t[WIDTH:0])  << (2 * gk);
        assign w_tree[0][2*gk+1] = C_PW'(r_s1_tc[gk].cy[WIDTH:0]) << (2 * gk + 1);

        if (WIDTH < C_MAX_WIDTH) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^{r_s1_tc[gk].t[C_VEC_W-1:WIDTH+1],
                                   r_s1_tc[gk].cy[C_VEC_W-1:WIDTH+1]};
        end
    end

    // Wallace-style 3:2 levels; slots beyond a level's live count are tied off.
    for (genvar gl = 0; gl < C_NLEV; gl++) begin : g_lvl
        localparam int C_NIN  = csa_count_at(C_NVEC, gl);
        localparam int C_NGRP = C_NIN / 3;
        localparam int C_NOUT = csa_next(C_NIN);

        for (genvar gj = 0; gj < C_NVEC; gj++) begin : g_slot
            if (gj < 2 * C_NGRP) begin : g_csa
                localparam int C_G = gj / 2;
                if ((gj % 2) == 0) begin : g_sum
                    assign w_tree[gl+1][gj] = w_tree[gl][3*C_G] ^ w_tree[gl][3*C_G+1]
                                            ^ w_tree[gl][3*C_G+2];
                end else begin : g_car
                    assign w_tree[gl+1][gj] = ((w_tree[gl][3*C_G]   & w_tree[gl][3*C_G+1])
                                             | (w_tree[gl][3*C_G]   & w_tree[gl][3*C_G+2])
                                             | (w_tree[gl][3*C_G+1] & w_tree[gl][3*C_G+2])) << 1;
                end
            end else if (gj < C_NOUT) begin : g_pass
                assign w_tree[gl+1][gj] = w_tree[gl][gj + C_NGRP];
            end else begin : g_zero
                assign w_tree[gl+1][gj] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            out_valid  <= 1'b0;
            p          <= '0;
            p_exact    <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
            out_valid  <= r_s2_valid;
            if (r_s2_valid) begin
                p       <= r_s2_sum + r_s2_car;
                p_exact <= r_s2_exact;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            if (in_valid) begin
                r_s1_tc    <= w_tc;
                r_s1_exact <= exact;
            end
            if (r_s1_valid) begin
                r_s2_sum   <= w_tree[C_NLEV][0];
                r_s2_car   <= w_tree[C_NLEV][1];
                r_s2_exact <= r_s1_exact;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_approx_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_mul_pipe
// Description : Self-checking bench for approx_mul_pipe against a row/pair
//               arithmetic model, plus an exhaustive exact-width instance.
// Revision    : 1.0
// ============================================================================
module tb_approx_mul_pipe;

    localparam int W  = 8;
    localparam int AC = 4;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, exact, out_valid, out_ready, p_exact;
    logic [W-1:0]  x, y;
    logic [PW-1:0] p;

    logic          z_rst, z_in_valid, z_in_ready, z_out_valid, z_p_exact;
    logic          z_exact = 1'b0;
    logic          z_out_ready = 1'b1;
    logic [W-1:0]  zx, zy;
    logic [PW-1:0] zp;
    logic          z_done = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int unsigned pv;
        bit          ev;
    } exp_t;

    exp_t          q [$];
    int unsigned   zq [$];
    bit            have_hold = 1'b0;
    logic [PW-1:0] hold_p;
    logic          hold_pe;

    approx_mul_pipe #(.WIDTH(W), .APPROX_COLS(AC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .exact(exact), .out_valid(out_valid),
        .out_ready(out_ready), .p(p), .p_exact(p_exact)
    );

    approx_mul_pipe #(.WIDTH(W), .APPROX_COLS(0)) dut_z (
        .clk(clk), .rst(z_rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .x(zx), .y(zy), .exact(z_exact), .out_valid(z_out_valid),
        .out_ready(z_out_ready), .p(zp), .p_exact(z_p_exact)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: result emitted with nothing pending (t=%0t)", name, $time);
    endtask

    // Sum of pair values built column by column from the row definitions.
    function automatic int unsigned model_p(input int unsigned xv, input int unsigned yv,
                                            input bit ex, input int w, input int ac);
        longint unsigned acc;
        longint unsigned t;
        longint unsigned cy;
        longint unsigned a;
        longint unsigned b;
        acc = 0;
        for (int k = 0; k < w / 2; k++) begin
            t  = 0;
            cy = 0;
            for (int c = 0; c <= w; c++) begin
                a = (c < w) ? longint'((xv >> (2*k)) & (yv >> c) & 1) : 0;
                b = (c > 0) ? longint'((xv >> (2*k+1)) & (yv >> (c-1)) & 1) : 0;
                if (!ex && (2*k + c < ac)) begin
                    t += (a | b) << c;
                end else begin
                    t  += (a ^ b) << c;
                    cy += (a & b) << c;
                end
            end
            acc += (t + (cy << 1)) << (2*k);
        end
        return int'(acc & ((64'd1 << (2*w)) - 1));
    endfunction

    // Compare process for the main instance: handshakes sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            have_hold = 1'b0;
        end else begin
            check("in_ready_eq_not_stall", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (have_hold) begin
                check("hold_out_valid", 32'(out_valid), 32'd1);
                check("hold_p", 32'(p), 32'(hold_p));
                check("hold_p_exact", 32'(p_exact), 32'(hold_pe));
            end
            have_hold = out_valid && !out_ready;
            hold_p    = p;
            hold_pe   = p_exact;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    fail_now("spurious_out");
                end else begin
                    e = q.pop_front();
                    check("p", 32'(p), e.pv);
                    check("p_exact", 32'(p_exact), 32'(e.ev));
                end
            end
            if (in_valid && in_ready)
                q.push_back('{model_p(32'(x), 32'(y), exact, W, AC), exact});
        end
    end

    always @(negedge clk) begin
        int unsigned ez;
        if (z_rst) begin
            zq.delete();
        end else begin
            if (z_out_valid) begin
                if (zq.size() == 0) begin
                    fail_now("exh_spurious_out");
                end else begin
                    ez = zq.pop_front();
                    check("exh_p", 32'(zp), ez);
                end
            end
            if (z_in_valid && z_in_ready) zq.push_back(32'(zx) * 32'(zy));
        end
    end

    initial begin
        z_rst = 1'b1;
        z_in_valid = 1'b0;
        zx = '0;
        zy = '0;
        repeat (3) @(posedge clk);
        #1 z_rst = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            @(posedge clk);
            #1;
            z_in_valid = 1'b1;
            zx = 8'(i);
            zy = 8'(i >> 8);
        end
        @(posedge clk);
        #1 z_in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("exh_drain", 32'(zq.size()), 32'd0);
        z_done = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before completion");
        n_vec++;
        n_miss++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        int unsigned ra, rb;

        // Pin the model to hand-computed values.
        check("model_255x255_exact", model_p(255, 255, 1'b1, W, AC), 32'd65025);
        check("model_3x3_approx", model_p(3, 3, 1'b0, W, AC), 32'd7);
        check("model_3x3_exact", model_p(3, 3, 1'b1, W, AC), 32'd9);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            check("model_exact_is_product", model_p(ra, rb, 1'b1, W, AC), ra * rb);
            check("model_approx_not_above", 32'(model_p(ra, rb, 1'b0, W, AC) <= ra * rb), 32'd1);
        end

        rst = 1'b1;
        in_valid = 1'b0;
        x = '0;
        y = '0;
        exact = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_p", 32'(p), 32'd0);
        check("reset_p_exact", 32'(p_exact), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Full-scale operands, latency counted from the accept edge.
        @(posedge clk); #1;
        in_valid = 1'b1; x = 8'd255; y = 8'd255; exact = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); check("lat_edge1_valid", 32'(out_valid), 32'd0);
        @(negedge clk); check("lat_edge2_valid", 32'(out_valid), 32'd0);
        @(negedge clk); check("lat_edge3_valid", 32'(out_valid), 32'd1);
        check("max_p", 32'(p), 32'd65025);
        check("max_p_exact", 32'(p_exact), 32'd1);

        // Same operands, approximate then exact, back to back.
        @(posedge clk); #1;
        in_valid = 1'b1; x = 8'd3; y = 8'd3; exact = 1'b0;
        @(posedge clk); #1;
        exact = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("3x3_approx_p", 32'(p), 32'd7);
        check("3x3_approx_flag", 32'(p_exact), 32'd0);
        @(negedge clk);
        check("3x3_exact_p", 32'(p), 32'd9);
        check("3x3_exact_flag", 32'(p_exact), 32'd1);

        // Back-to-back random stream with alternating mode.
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            x = 8'($urandom);
            y = 8'($urandom);
            exact = 1'(i & 1);
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 32'd1);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("stream_drain", 32'(q.size()), 32'd0);

        // Stall with three results in flight while a fourth is offered.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            x = 8'($urandom);
            y = 8'($urandom);
            exact = 1'($urandom);
        end
        @(posedge clk); #1;
        x = 8'($urandom);
        y = 8'($urandom);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk); check("release_0_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); check("release_1_valid", 32'(out_valid), 32'd1);
        @(negedge clk); check("release_2_valid", 32'(out_valid), 32'd1);
        @(negedge clk); check("release_3_valid", 32'(out_valid), 32'd1);
        repeat (4) @(posedge clk);
        #1 check("stall_drain", 32'(q.size()), 32'd0);

        // Random valid and backpressure to mix bubbles with stalls.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            x = 8'($urandom);
            y = 8'($urandom);
            exact = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("random_drain", 32'(q.size()), 32'd0);

        // Reset pulse with two transactions in flight.
        @(posedge clk); #1;
        in_valid = 1'b1; x = 8'd200; y = 8'd100; exact = 1'b1;
        @(posedge clk); #1;
        x = 8'd17; y = 8'd33; exact = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_p", 32'(p), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_stale", 32'(out_valid), 32'd0);
        end

        wait (z_done);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
